// File: rtl/sar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : sar_scan_controller
// Brief    : Multi-channel conversion sequencer for a SAR ADC core. Steps the
//            analog mux over the enabled channels, times the acquisition
//            window, pulses the SAR start, and hands tagged results to a
//            valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module sar_scan_controller #(
    parameter int NOB     = 10,
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int ACQ_W   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [NCH-1:0]   ch_mask_i,
    input  logic [ACQ_W-1:0] acq_cycles_i,
    input  logic             continuous_i,
    input  logic             trigger_i,
    input  logic             adc_eoc_i,
    input  logic [NOB-1:0]   adc_data_i,
    output logic [CHW-1:0]   mux_sel_o,
    output logic             sample_o,
    output logic             adc_start_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [NOB-1:0]   res_data_o,
    output logic [CHW-1:0]   res_ch_o,
    output logic             busy_o,
    output logic             scan_done_o,
    output logic             overrun_o,
    output logic             timeout_err_o
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_ACQ    = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_CONV   = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CHW-1:0]   cur_q, cur_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [ACQ_W-1:0] acq_q, acq_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CHW-1:0]   mux_sel_q;
    logic             res_valid_q;
    logic [NOB-1:0]   res_data_q;
    logic [CHW-1:0]   res_ch_q;
    logic             scan_done_q, scan_done_d;
    logic             overrun_q;
    logic             timeout_err_q;

    logic             low_found;
    logic [CHW-1:0]   low_idx;
    logic             nxt_found;
    logic [CHW-1:0]   nxt_idx;
    logic             start_scan;
    logic             load_res;
    logic             timeout_set;

    // Lowest set bit of the live mask, and next latched channel above cur.
    // Descending loops leave the lowest qualifying index in the result.
    always_comb begin
        low_found = 1'b0;
        low_idx   = '0;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                low_found = 1'b1;
                low_idx   = CHW'(i);
            end
            if (mask_q[i] && (i > int'(cur_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = CHW'(i);
            end
        end
    end

    // Sequencer next-state logic; a dropped enable overrides everything.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        mask_d      = mask_q;
        acq_d       = acq_q;
        to_d        = to_q;
        scan_done_d = 1'b0;
        start_scan  = 1'b0;
        load_res    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && low_found && (continuous_i || trigger_i)) begin
                    start_scan = 1'b1;
                    mask_d     = ch_mask_i;
                    cur_d      = low_idx;
                    state_d    = ST_SELECT;
                end
            end
            ST_SELECT: begin
                acq_d   = acq_cycles_i;
                state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (acq_q == '0) begin
                    state_d = ST_START;
                end else begin
                    acq_d = acq_q - ACQ_W'(1);
                end
            end
            ST_START: begin
                to_d    = '0;
                state_d = ST_CONV;
            end
            ST_CONV: begin
                if (adc_eoc_i) begin
                    load_res = 1'b1;
                    state_d  = ST_NEXT;
                end else if (to_q == TO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_NEXT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_NEXT: begin
                if (nxt_found) begin
                    cur_d   = nxt_idx;
                    state_d = ST_SELECT;
                end else begin
                    scan_done_d = 1'b1;
                    if (enable_i && continuous_i && low_found) begin
                        mask_d  = ch_mask_i;
                        cur_d   = low_idx;
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && !enable_i) begin
            state_d     = ST_IDLE;
            cur_d       = cur_q;
            mask_d      = mask_q;
            scan_done_d = 1'b0;
            load_res    = 1'b0;
            timeout_set = 1'b0;
        end
    end

    // Sequencer state registers; mux select follows cur on entry to SELECT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            mask_q      <= '0;
            acq_q       <= '0;
            to_q        <= '0;
            mux_sel_q   <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            mask_q      <= mask_d;
            acq_q       <= acq_d;
            to_q        <= to_d;
            scan_done_q <= scan_done_d;
            if (state_d == ST_SELECT) begin
                mux_sel_q <= cur_d;
            end
        end
    end

    // Result holding register with valid/ready handshake; a new load wins
    // over a same-edge transfer so valid stays high with fresh data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
        end else if (load_res) begin
            res_valid_q <= 1'b1;
            res_data_q  <= adc_data_i;
            res_ch_q    <= cur_q;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    // Sticky error flags, cleared when a fresh scan starts from idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else if (start_scan) begin
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (load_res && res_valid_q && !res_ready_i) begin
                overrun_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    // Strobes are gated by enable so an abort never samples or starts.
    assign sample_o      = (state_q == ST_ACQ) && enable_i;
    assign adc_start_o   = (state_q == ST_START) && enable_i;
    assign busy_o        = (state_q != ST_IDLE);
    assign mux_sel_o     = mux_sel_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_ch_o      = res_ch_q;
    assign scan_done_o   = scan_done_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_scan_controller
// Brief    : Directed self-checking bench for sar_scan_controller with a
//            simple fixed-latency SAR core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_scan_controller;

    localparam int SAR_LAT = 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, continuous, trigger, adc_eoc, res_ready;
    logic [3:0] ch_mask;
    logic [7:0] acq_cycles;
    logic [9:0] adc_data;
    logic [1:0] mux_sel, res_ch;
    logic       sample, adc_start, res_valid, busy, scan_done, overrun, timeout_err;
    logic [9:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    sar_scan_controller dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .ch_mask_i    (ch_mask),
        .acq_cycles_i (acq_cycles),
        .continuous_i (continuous),
        .trigger_i    (trigger),
        .adc_eoc_i    (adc_eoc),
        .adc_data_i   (adc_data),
        .mux_sel_o    (mux_sel),
        .sample_o     (sample),
        .adc_start_o  (adc_start),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_ch_o     (res_ch),
        .busy_o       (busy),
        .scan_done_o  (scan_done),
        .overrun_o    (overrun),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // SAR core model: eoc pulses SAR_LAT cycles after the start pulse.
    int         sar_cnt = 0;
    bit         sar_en  = 1'b1;
    logic [1:0] sar_ch  = 2'd0;
    initial begin
        adc_eoc  = 1'b0;
        adc_data = '0;
    end
    always @(negedge clk) begin
        adc_eoc = 1'b0;
        if (adc_start) begin
            sar_cnt = SAR_LAT;
            sar_ch  = mux_sel;
        end else if (sar_cnt > 0) begin
            sar_cnt--;
            if (sar_cnt == 0 && sar_en) begin
                adc_eoc  = 1'b1;
                adc_data = 10'h200 + {8'h00, sar_ch};
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    int          samp_run, overlap_err, gap_err, done_cnt, valid_cycles, to_cyc;
    bit          prev_samp;
    int          q_acq[$];
    int          start_ch_q[$];
    int          start_cyc_q[$];
    int          done_cyc_q[$];
    logic [11:0] res_q[$];

    always @(negedge clk) begin
        if (sample) samp_run++;
        else if (prev_samp) begin
            q_acq.push_back(samp_run);
            samp_run = 0;
        end
        if (sample && adc_start) overlap_err++;
        if (adc_start && !prev_samp) gap_err++;
        if (adc_start) begin
            start_ch_q.push_back(int'(mux_sel));
            start_cyc_q.push_back(cyc);
        end
        if (scan_done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
        end
        if (res_valid && res_ready) res_q.push_back({res_ch, res_data});
        if (res_valid) valid_cycles++;
        if (timeout_err && to_cyc < 0) to_cyc = cyc;
        prev_samp = sample;
    end

    task automatic clear_mon();
        samp_run = 0; overlap_err = 0; gap_err = 0; done_cnt = 0;
        valid_cycles = 0; to_cyc = -1;
        q_acq.delete(); start_ch_q.delete(); start_cyc_q.delete();
        done_cyc_q.delete(); res_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [3:0] m, input logic cont);
        ch_mask = m; continuous = cont; enable = 1'b1; trigger = 1'b1;
        clear_mon();
        tick();
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst_n = 1'b0; enable = 1'b0; ch_mask = '0; acq_cycles = 8'd3;
        continuous = 1'b0; trigger = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {mux_sel, sample, adc_start, res_valid, res_data, res_ch,
               busy, scan_done, overrun, timeout_err};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, expected 0", got);
        end
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %0b, expected 0", busy);
        end
    endtask

    task automatic test_single_scan();
        logic [11:0] exp_r [3] = '{12'h200, 12'h601, 12'hE03};
        int n = 0;
        res_ready = 1'b1; acq_cycles = 8'd3; sar_en = 1'b1;
        start_scan(4'b1011, 1'b0);
        while (busy && n < 500) begin tick(); n++; end
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0b, expected 0", busy); end
        n_checks++;
        if (res_q.size() != 3) begin n_fail++; $display("FAIL single_res_count: got %0d, expected 3", res_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res_q[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL single_res%0d {ch,data}: got %0h, expected %0h", i, res_q[i], exp_r[i]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL single_scan_done: got %0d, expected 1", done_cnt); end
        n_checks++;
        if (q_acq.size() != 3) begin n_fail++; $display("FAIL single_acq_windows: got %0d, expected 3", q_acq.size()); end
        for (int i = 0; i < q_acq.size(); i++) begin
            n_checks++;
            if (q_acq[i] != 4) begin n_fail++; $display("FAIL single_acq_len%0d: got %0d, expected 4", i, q_acq[i]); end
        end
        n_checks++;
        if (overlap_err != 0 || gap_err != 0) begin
            n_fail++;
            $display("FAIL single_sample_start_timing: got overlap %0d gap %0d, expected 0 0", overlap_err, gap_err);
        end
    endtask

    task automatic test_continuous();
        int n = 0;
        res_ready = 1'b1;
        ch_mask = 4'b0100; continuous = 1'b1; enable = 1'b1;
        clear_mon();
        while (done_cnt < 3 && n < 300) begin tick(); n++; end
        enable = 1'b0; continuous = 1'b0;
        tick(); tick();
        n_checks++;
        if (res_q.size() != 3) begin n_fail++; $display("FAIL cont_res_count: got %0d, expected 3", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_checks++;
            if (res_q[i] !== 12'h A02) begin n_fail++; $display("FAIL cont_res%0d: got %0h, expected a02", i, res_q[i]); end
        end
        for (int i = 1; i < done_cyc_q.size(); i++) begin
            n_checks++;
            if (done_cyc_q[i] - done_cyc_q[i-1] != 18) begin
                n_fail++;
                $display("FAIL cont_period%0d: got %0d, expected 18", i, done_cyc_q[i] - done_cyc_q[i-1]);
            end
        end
        n_checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_overrun_busy: got %0b%0b, expected 00", overrun, busy);
        end
    endtask

    task automatic test_overrun();
        int n = 0;
        res_ready = 1'b0;
        start_scan(4'b0011, 1'b0);
        while (busy && n < 200) begin tick(); n++; end
        n_checks++;
        if ({res_valid, overrun, res_ch, res_data} !== {1'b1, 1'b1, 2'd1, 10'h201}) begin
            n_fail++;
            $display("FAIL overrun_state {valid,ovr,ch,data}: got %0b %0b %0d %0h, expected 1 1 1 201",
                     res_valid, overrun, res_ch, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_drain {valid,ovr}: got %0b %0b, expected 0 1", res_valid, overrun);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        sar_en = 1'b0; res_ready = 1'b1;
        start_scan(4'b0011, 1'b0);
        while (busy && n < 300) begin tick(); n++; end
        tick(); tick();
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %0b, expected 1", timeout_err); end
        n_checks++;
        if (start_cyc_q.size() < 1 || to_cyc - start_cyc_q[0] != 32) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d, expected 32", (start_cyc_q.size() > 0) ? to_cyc - start_cyc_q[0] : -1);
        end
        n_checks++;
        if (valid_cycles != 0) begin n_fail++; $display("FAIL timeout_no_result: got %0d valid cycles, expected 0", valid_cycles); end
        n_checks++;
        if (start_ch_q.size() != 2 || start_ch_q[1] != 1) begin
            n_fail++;
            $display("FAIL timeout_advance: got %0d starts, expected 2 with second on ch1", start_ch_q.size());
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL timeout_scan_done: got %0d, expected 1", done_cnt); end
        sar_en = 1'b1;
    endtask

    task automatic test_abort();
        int n = 0;
        res_ready = 1'b0;
        start_scan(4'b0011, 1'b0);
        while (start_ch_q.size() < 2 && n < 200) begin tick(); n++; end
        enable = 1'b0;
        tick();
        n_checks++;
        if ({busy, sample, adc_start, mux_sel} !== {1'b0, 1'b0, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL abort_idle {busy,sample,start,mux}: got %0b %0b %0b %0d, expected 0 0 0 1",
                     busy, sample, adc_start, mux_sel);
        end
        n_checks++;
        if ({res_valid, res_ch, res_data} !== {1'b1, 2'd0, 10'h200}) begin
            n_fail++;
            $display("FAIL abort_held {valid,ch,data}: got %0b %0d %0h, expected 1 0 200", res_valid, res_ch, res_data);
        end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL abort_timeout_cleared: got %0b, expected 0", timeout_err); end
        repeat (15) tick();
        n_checks++;
        if ({busy, res_data, done_cnt[3:0]} !== {1'b0, 10'h200, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_after {busy,data,done}: got %0b %0h %0d, expected 0 200 0", busy, res_data, done_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_acq();
        int n = 0;
        ch_mask = 4'b0100; continuous = 1'b1; enable = 1'b1; res_ready = 1'b0;
        clear_mon();
        while (!sample && n < 100) begin tick(); n++; end
        n_checks++;
        if ({sample, mux_sel} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL rst_pre_acq {sample,mux}: got %0b %0d, expected 1 2", sample, mux_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sample, adc_start, busy, mux_sel, res_valid, scan_done, overrun, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got %0b %0b %0b %0d %0b %0b %0b %0b, expected all 0",
                     sample, adc_start, busy, mux_sel, res_valid, scan_done, overrun, timeout_err);
        end
        continuous = 1'b0; trigger = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stays_idle: got %0b, expected 0", busy); end
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_trigger_starts: got %0b, expected 1", busy); end
        enable = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_scan();
        test_continuous();
        test_overrun();
        test_timeout();
        test_abort();
        test_reset_mid_acq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sar_scan_controller.md
# sar_scan_controller

Multi-channel conversion sequencer in front of the SAR ADC core: steps an analog input mux, times the sample/hold acquisition window and issues one-cycle start pulses to the SAR core. It collects each `NOB`-bit result on `adc_eoc` and hands it to a downstream consumer over a valid/ready interface, tagged with its channel number. It sits between the register/configuration side and the SAR core, and is the only block that starts conversions.

## Interface
- `NOB`, 10, ADC resolution in bits (matches the SAR core).
- `NCH`, 4, number of mux channels.
- `CHW`, 2, channel index width, equal to clog2(`NCH`).
- `ACQ_W`, 8, acquisition counter width.
- `TIMEOUT`, 31, maximum CONV cycles to wait for `adc_eoc`.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: scan enable.
- `ch_mask` in `NCH`: channel enable mask; bit i enables channel i.
- `acq_cycles` in `ACQ_W`: acquisition length; ACQ lasts `acq_cycles`+1 cycles.
- `continuous` in 1: 1 means restart scans back-to-back; 0 means one scan per `trigger`.
- `trigger` in 1: single-scan request, sampled in IDLE.
- `adc_eoc` in 1: end-of-conversion from the SAR core.
- `adc_data` in `NOB`: SAR core result; valid while `adc_eoc` is 1.
- `mux_sel` out `CHW`: analog mux select.
- `sample` out 1: S/H track enable.
- `adc_start` out 1: one-cycle conversion start pulse.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out `NOB`: result value.
- `res_ch` out `CHW`: channel of `res_data`.
- `busy` out 1: high in every state except IDLE.
- `scan_done` out 1: one-cycle pulse at the end of each scan.
- `overrun` out 1: sticky; an unread result was overwritten.
- `timeout_err` out 1: sticky; `adc_eoc` was missed.

## Operation
- All outputs reset to 0; FSM resets to IDLE.
- FSM states are IDLE, SELECT, ACQ, START, CONV and NEXT.
- IDLE:
  - Scan starts when `enable`=1, `ch_mask`≠0 and (`continuous`=1 or `trigger`=1).
  - On start, latch `ch_mask` into `mask_q`, set `cur` to the lowest set bit, go to SELECT.
  - Otherwise `trigger` is ignored.
- SELECT: drive `mux_sel`=`cur`; load the acquisition counter with `acq_cycles`; go to ACQ.
- ACQ: `sample`=1; decrement the counter each cycle; when the counter is 0, go to START.
- START: `adc_start`=1 for exactly this cycle; `sample`=0; clear the timeout counter; go to CONV.
- CONV: wait for `adc_eoc`=1.
  - On `adc_eoc`=1, register `adc_data` into `res_data` and `cur` into `res_ch`, set `res_valid`=1, go to NEXT.
  - If the timeout counter reaches `TIMEOUT`, set `timeout_err`, emit no result, go to NEXT.
- NEXT:
  - If `mask_q` has a set bit above `cur`, set `cur` to the next set bit and go to SELECT.
  - Otherwise pulse `scan_done`.
    - If `enable`=1 and `continuous`=1, re-latch `ch_mask`. If it is nonzero, go to SELECT at its lowest bit; if it is zero, go to IDLE.
    - Else go to IDLE.
- Result handshake:
  - A transfer occurs on an edge where `res_valid`=1 and `res_ready`=1.
  - `res_valid` falls after the transfer unless a new result loads on the same edge; in that case it stays 1 with the new data and no overrun.
  - If a new result loads while `res_valid`=1 and `res_ready`=0, the old data is overwritten and `overrun` is set.
- `enable` dropping in any non-IDLE state:
  - FSM goes to IDLE on the next edge.
  - `sample` and `adc_start` are 0; `mux_sel` holds.
  - A pending result stays valid until consumed.
  - No `scan_done` pulse.
- `overrun` and `timeout_err` clear only on reset, or on a scan start from IDLE.
- `ch_mask` changes mid-scan have no effect until the next latch point.

## Timing
- Per-channel cycles: SELECT 1 + ACQ (`acq_cycles`+1) + START 1 + CONV (to `adc_eoc`) + NEXT 1.
- `adc_start` rises in the cycle after `sample` falls; `sample` is never high while `adc_start` is high.
- `res_valid` is high on the edge that samples `adc_eoc`=1.
- Scan restart in continuous mode: NEXT to SELECT with no idle cycle.
- Single-channel mask: scan wraps onto the same channel; `scan_done` pulses once per conversion.

## Test plan
- **Single scan:** `ch_mask`=4'b1011, `continuous`=0, `acq_cycles`=3, trigger pulse, SAR model returns 0x200+ch after 11 cycles.
  - Results in order: (ch0,0x200), (ch1,0x201), (ch3,0x203).
  - `scan_done` pulses once; then IDLE with `busy`=0.
  - Each ACQ window is exactly 4 cycles of `sample`=1.
- **Continuous:** `ch_mask`=4'b0100, `continuous`=1, `res_ready` tied 1.
  - Back-to-back ch2 results.
  - `scan_done` pulses after each result; `overrun`=0.
- **Overrun:** `ch_mask`=4'b0011, `res_ready`=0.
  - `res_data` ends as the ch1 value; `overrun`=1; `res_valid` stays 1.
  - Asserting `res_ready` for 1 cycle drops `res_valid`.
- **Timeout:** SAR model never asserts `adc_eoc`.
  - `timeout_err`=1 after 31 CONV cycles; no `res_valid`.
  - FSM advances to the next channel.
- **Abort:** drop `enable` during CONV of ch1.
  - IDLE next cycle, `busy`=0, no `scan_done`.
  - The earlier ch0 result is still held.
- **Reset:** assert `rst`=0 during ACQ.
  - All outputs 0 asynchronously; after release, FSM idles until triggered.
